zoom_out_average: RTL

Downscaling engine, the inverse of the replication zoom-in. It reads a source image from ROM and averages each 2x2 pixel block into one output pixel. The result is written packed into the frame RAM at half width and half height. It sits beside the zoom-in engine behind the top-level memory bus multiplexer: the controller drives `start`, muxes this block's ROM/RAM buses onto the memory module while `busy` is high, and waits for `done`.

---
 rtl/zoom_out_average.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/zoom_out_average.sv
// zoom_out_average: 2x2 box-filter downscaler.
// Reads a W x H source image from ROM one pixel per cycle (a0, a1, a2, a3 of each
// 2x2 block), averages the four values with round-half-up and writes the result
// into the frame RAM at (W/2) x (H/2), packed in raster order. The ROM has a
// one-cycle read latency, so every datum is tagged with the phase of the address
// that produced it, one cycle late.
module zoom_out_average #(
   parameter int ROM_AW = 17,
   parameter int RAM_AW = 19,
   parameter int DW     = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       img_width,
   input  logic [15:0]       img_height,
   input  logic [DW-1:0]     rom_data_in,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW-1:0]     ram_data,
   output logic              ram_wren,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t              state;
   logic [15:0]         w_reg;        // source width
   logic [14:0]         wo_reg;       // output width
   logic [14:0]         ho_reg;       // output height
   logic [14:0]         ox;           // output column of the pixel being issued
   logic [14:0]         oy;           // output row of the pixel being issued
   logic [ROM_AW-1:0]   row_base;     // 2*oy*W
   logic [ROM_AW-1:0]   col_off;      // 2*ox
   logic [1:0]          phase;        // which of a0..a3 is on rom_addr now
   logic                cap_valid;    // rom_data_in this cycle belongs to an issued read
   logic [1:0]          cap_phase;    // phase of the read that rom_data_in answers
   logic [DW+1:0]       acc;          // running sum of the current block
   logic [RAM_AW-1:0]   wr_pix;       // next output pixel index

   logic [ROM_AW-1:0]   w_rom;
   logic [ROM_AW-1:0]   row_step;
   logic [ROM_AW-1:0]   pix_a0;
   logic [DW+1:0]       sum;
   logic                last_col;
   logic                last_row;

   // Address and sum helpers: adders only, no multiplier.
   always_comb begin
      w_rom    = ROM_AW'(w_reg);
      row_step = w_rom << 1;
      pix_a0   = row_base + col_off;
      sum      = acc + {2'b00, rom_data_in};
      last_col = (ox == wo_reg - 15'd1);
      last_row = (oy == ho_reg - 15'd1);
   end

   // Control FSM, read-address generation, accumulation and RAM write.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         w_reg     <= '0;
         wo_reg    <= '0;
         ho_reg    <= '0;
         ox        <= '0;
         oy        <= '0;
         row_base  <= '0;
         col_off   <= '0;
         phase     <= '0;
         cap_valid <= 1'b0;
         cap_phase <= '0;
         acc       <= '0;
         wr_pix    <= '0;
         rom_addr  <= '0;
         ram_addr  <= '0;
         ram_data  <= '0;
         ram_wren  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         ram_wren <= 1'b0;

         // Capture the datum returned for last cycle's address.
         if (cap_valid) begin
            if (cap_phase == 2'd0)
               acc <= {2'b00, rom_data_in};
            else
               acc <= sum;
            if (cap_phase == 2'd3) begin
               ram_data <= DW'((sum + (DW+2)'(2)) >> 2);
               ram_addr <= wr_pix;
               ram_wren <= 1'b1;
               wr_pix   <= wr_pix + RAM_AW'(1);
            end
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  w_reg     <= img_width;
                  wo_reg    <= img_width[15:1];
                  ho_reg    <= img_height[15:1];
                  ox        <= '0;
                  oy        <= '0;
                  row_base  <= '0;
                  col_off   <= '0;
                  phase     <= '0;
                  cap_valid <= 1'b0;
                  wr_pix    <= '0;
                  rom_addr  <= '0;
                  if (img_width < 16'd2 || img_height < 16'd2) begin
                     // Nothing to produce: finish without touching memory.
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
            end

            RUN: begin
               cap_valid <= 1'b1;
               cap_phase <= phase;
               phase     <= phase + 2'd1;
               case (phase)
                  2'd0: rom_addr <= pix_a0 + ROM_AW'(1);
                  2'd1: rom_addr <= pix_a0 + w_rom;
                  2'd2: rom_addr <= pix_a0 + w_rom + ROM_AW'(1);
                  default: begin
                     if (last_col && last_row) begin
                        // Last a3 is out; rom_addr holds it from here on.
                        state <= FLUSH;
                     end else if (last_col) begin
                        ox       <= '0;
                        oy       <= oy + 15'd1;
                        col_off  <= '0;
                        row_base <= row_base + row_step;
                        rom_addr <= row_base + row_step;
                     end else begin
                        ox       <= ox + 15'd1;
                        col_off  <= col_off + ROM_AW'(2);
                        rom_addr <= pix_a0 + ROM_AW'(2);
                     end
                  end
               endcase
            end

            FLUSH: begin
               // First cycle takes the final datum; the next one retires the pass.
               cap_valid <= 1'b0;
               if (!cap_valid) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
